// File: rtl/display_drop_pkg.sv
// Shared state encoding, seven-segment glyphs and 4-character messages for the drop display blocks.
package display_drop_pkg;

  typedef enum logic [1:0] {
    ST_COLD = 2'd0,
    ST_HOT  = 2'd1,
    ST_DROP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Glyphs are bit6=g .. bit0=a, active-high
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_O     = 7'b1011100;
  localparam logic [6:0] SEG_L     = 7'b0111000;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_R     = 7'b1010000;
  localparam logic [6:0] SEG_P     = 7'b1110011;
  localparam logic [6:0] SEG_H     = 7'b1110110;
  localparam logic [6:0] SEG_T     = 7'b1111000;
  localparam logic [6:0] SEG_N     = 7'b1010100;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [27:0] MSG_COLD = {SEG_C, SEG_O, SEG_L, SEG_D};
  localparam logic [27:0] MSG_HOT  = {SEG_BLANK, SEG_H, SEG_O, SEG_T};
  localparam logic [27:0] MSG_DROP = {SEG_D, SEG_R, SEG_O, SEG_P};
  localparam logic [27:0] MSG_DONE = {SEG_D, SEG_O, SEG_N, SEG_E};

  function automatic logic [27:0] msg_of(input state_t s);
    case (s)
      ST_HOT:  return MSG_HOT;
      ST_DROP: return MSG_DROP;
      ST_DONE: return MSG_DONE;
      default: return MSG_COLD;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Time-multiplexes a parallel seven-segment bus onto one digit at a time.
// Each digit is held for SCAN_DIV cycles; seg_mux follows seg_bus combinationally for the selected digit.
module seg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7*NUM_DIGITS-1:0] seg_bus,
  output logic [6:0]              seg_mux,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0]         r_cnt;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [6:0]            w_mux;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sel <= NUM_DIGITS'(1);
    end else if (r_cnt == CW'(SCAN_DIV - 1)) begin
      r_cnt <= '0;
      r_sel <= {r_sel[NUM_DIGITS-2:0], r_sel[NUM_DIGITS-1]};
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Digit 0 sits in the MSBs of the bus
  always_comb begin
    w_mux = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_sel[i]) w_mux = w_mux | seg_bus[7*(NUM_DIGITS-1-i) +: 7];
    end
  end

  assign seg_mux = w_mux;
  assign dig_sel = r_sel;

endmodule

// File: rtl/display_and_drop_ctrl.sv
// Baggage-drop decision FSM (COLD/HOT/DROP/DONE) with timed drop pulse and seven-segment status message.
// All outputs come from registers; input changes appear on outputs one cycle later.
module display_and_drop_ctrl
  import display_drop_pkg::*;
#(
  parameter int T_WIDTH    = 16,
  parameter int NUM_DIGITS = 4,
  parameter int DROP_HOLD  = 8,
  parameter int HYST       = 2,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_WIDTH-1:0]      t_act,
  input  logic [T_WIDTH-1:0]      t_lim,
  input  logic                    drop_en,
  output logic                    drop_activated,
  output logic [7*NUM_DIGITS-1:0] seg_bus,
  output logic [6:0]              seg_mux,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [1:0]              state_o
);

  localparam int BW = 7 * NUM_DIGITS;
  localparam int HW = (DROP_HOLD > 1) ? $clog2(DROP_HOLD) : 1;
  localparam logic [T_WIDTH:0] HYST_W = (T_WIDTH+1)'(HYST);

  state_t          r_state, w_next;
  logic [HW-1:0]   r_hold, w_hold_next;
  logic            r_drop;
  logic [BW-1:0]   r_seg;
  logic [T_WIDTH:0] w_thr;
  logic            w_below, w_cool;

  assign w_below = t_act < t_lim;
  // Threshold saturates at zero so small limits never wrap into a huge value
  assign w_thr   = ({1'b0, t_lim} >= HYST_W) ? ({1'b0, t_lim} - HYST_W) : '0;
  assign w_cool  = {1'b0, t_act} < w_thr;

  always_comb begin
    w_next      = r_state;
    w_hold_next = '0;
    case (r_state)
      ST_COLD: if (drop_en) w_next = w_below ? ST_DROP : ST_HOT;
      ST_HOT: begin
        if (!drop_en)    w_next = ST_COLD;
        else if (w_cool) w_next = ST_DROP;
      end
      ST_DROP: begin
        if (!drop_en)                            w_next = ST_COLD;
        else if (r_hold == HW'(DROP_HOLD - 1))   w_next = ST_DONE;
      end
      ST_DONE: if (!drop_en) w_next = ST_COLD;
      default: w_next = ST_COLD;
    endcase
    if (r_state == ST_DROP && w_next == ST_DROP) w_hold_next = r_hold + HW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_COLD;
      r_hold  <= '0;
      r_drop  <= 1'b0;
      r_seg   <= BW'(MSG_COLD);
    end else begin
      r_state <= w_next;
      r_hold  <= w_hold_next;
      r_drop  <= (w_next == ST_DROP);
      r_seg   <= BW'(msg_of(w_next));
    end
  end

  seg_scan_mux #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .seg_bus (r_seg),
    .seg_mux (seg_mux),
    .dig_sel (dig_sel)
  );

  assign drop_activated = r_drop;
  assign seg_bus        = r_seg;
  assign state_o        = r_state;

endmodule

// File: tb/tb_display_and_drop_ctrl.sv
// Bench for display_and_drop_ctrl with a 6-digit, 3-cycle scan configuration.
module tb_display_and_drop_ctrl;

  localparam int TW = 16;
  localparam int ND = 6;
  localparam int DH = 8;
  localparam int HY = 2;
  localparam int SD = 3;

  localparam logic [6:0] S_C = 7'b0111001, S_O = 7'b1011100, S_L = 7'b0111000,
                         S_D = 7'b1011110, S_R = 7'b1010000, S_P = 7'b1110011,
                         S_H = 7'b1110110, S_T = 7'b1111000, S_N = 7'b1010100,
                         S_E = 7'b1111001;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [TW-1:0]   t_act = '0;
  logic [TW-1:0]   t_lim = '0;
  logic            drop_en = 1'b0;
  logic            drop_activated;
  logic [7*ND-1:0] seg_bus;
  logic [6:0]      seg_mux;
  logic [ND-1:0]   dig_sel;
  logic [1:0]      state_o;

  int checks = 0;
  int failures = 0;

  display_and_drop_ctrl #(
    .T_WIDTH(TW), .NUM_DIGITS(ND), .DROP_HOLD(DH), .HYST(HY), .SCAN_DIV(SD)
  ) dut (
    .clk(clk), .rst(rst), .t_act(t_act), .t_lim(t_lim), .drop_en(drop_en),
    .drop_activated(drop_activated), .seg_bus(seg_bus), .seg_mux(seg_mux),
    .dig_sel(dig_sel), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string msg_of(input int s);
    case (s)
      1: return " Hot";
      2: return "droP";
      3: return "donE";
      default: return "CoLd";
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input byte c);
    case (c)
      "C": return S_C;  "o": return S_O;  "L": return S_L;  "d": return S_D;
      "r": return S_R;  "P": return S_P;  "H": return S_H;  "t": return S_T;
      "n": return S_N;  "E": return S_E;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic byte char_at(input int s, input int d);
    string m;
    m = msg_of(s);
    if (d < ND - 4) return " ";
    return m[d - (ND - 4)];
  endfunction

  // Model: state as spec code, m_age = DROP cycles shown so far, m_ticks = cycles since reset
  int m_state = 0;
  int m_age = 0;
  int m_ticks = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_age = 0; m_ticks = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_ticks++;
      case (m_state)
        0: if (drop_en) begin
             if (t_act < t_lim) begin m_state = 2; m_age = 1; end
             else m_state = 1;
           end
        1: if (!drop_en) m_state = 0;
           else if (int'(t_act) < int'(t_lim) - HY) begin m_state = 2; m_age = 1; end
        2: if (!drop_en) m_state = 0;
           else if (m_age == DH) m_state = 3;
           else m_age++;
        default: if (!drop_en) m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [7*ND-1:0] e_bus;
      int idx;
      for (int d = 0; d < ND; d++) e_bus[7*(ND-1-d) +: 7] = seg_of(char_at(m_state, d));
      idx = (m_ticks / SD) % ND;
      chk("m_state", 64'(state_o), 64'(m_state));
      chk("m_drop", 64'(drop_activated), 64'(m_state == 2));
      chk("m_seg_bus", 64'(seg_bus), 64'(e_bus));
      chk("m_dig_sel", 64'(dig_sel), 64'(1) << idx);
      chk("m_seg_mux", 64'(seg_mux), 64'(seg_of(char_at(m_state, idx))));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_drop(output int n);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (drop_activated) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    bit found;
    rst = 1'b1; drop_en = 1'b0; t_lim = 16'd100; t_act = 16'd50;
    tick(); tick();
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_drop", 64'(drop_activated), 64'd0);
    chk("rst_seg_bus", 64'(seg_bus), 64'({14'b0, 7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110}));
    chk("rst_dig_sel", 64'(dig_sel), 64'(6'b000001));
    chk("rst_seg_mux", 64'(seg_mux), 64'd0);

    // Full drop from COLD with t_act below limit
    rst = 1'b0; drop_en = 1'b1;
    tick();
    chk("drop_entry_state", 64'(state_o), 64'd2);
    chk("drop_entry_msg", 64'(seg_bus[27:0]), 64'({S_D, S_R, S_O, S_P}));
    count_drop(n);
    chk("hold_len_1", 64'(n), 64'd8);
    chk("done_state", 64'(state_o), 64'd3);
    chk("done_msg", 64'(seg_bus[27:0]), 64'({S_D, S_O, S_N, S_E}));
    tick(); tick();
    chk("done_stays", 64'(state_o), 64'd3);
    chk("done_no_redrop", 64'(drop_activated), 64'd0);
    drop_en = 1'b0;
    tick();
    chk("done_to_cold", 64'(state_o), 64'd0);

    // HOT entry at equality, hysteresis boundary
    t_act = 16'd100; drop_en = 1'b1;
    tick();
    chk("hot_equal", 64'(state_o), 64'd1);
    chk("hot_msg", 64'(seg_bus[27:0]), 64'({7'b0, S_H, S_O, S_T}));
    t_act = 16'd99; tick(); tick();
    chk("hot_99", 64'(state_o), 64'd1);
    t_act = 16'd98; tick();
    chk("hot_98", 64'(state_o), 64'd1);
    t_act = 16'd97; tick();
    chk("hot_97_drop", 64'(state_o), 64'd2);

    // Abort at hold count 3, then full hold again
    tick(); tick(); tick();
    drop_en = 1'b0; tick();
    chk("abort_state", 64'(state_o), 64'd0);
    chk("abort_drop", 64'(drop_activated), 64'd0);
    drop_en = 1'b1; tick();
    chk("rearm_drop", 64'(drop_activated), 64'd1);
    count_drop(n);
    chk("hold_len_2", 64'(n), 64'd8);
    drop_en = 1'b0; tick();

    // Reset in the middle of DROP
    t_act = 16'd50; drop_en = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1; tick();
    chk("rst_mid_drop", 64'(drop_activated), 64'd0);
    chk("rst_mid_state", 64'(state_o), 64'd0);
    chk("rst_mid_msg", 64'(seg_bus[27:0]), 64'({S_C, S_O, S_L, S_D}));
    rst = 1'b0; tick();
    count_drop(n);
    chk("hold_len_3", 64'(n), 64'd8);
    drop_en = 1'b0; tick();

    // Saturating threshold: limit 1 leaves no cool value
    t_lim = 16'd1; t_act = 16'd1; drop_en = 1'b1;
    tick();
    t_act = 16'd0; tick(); tick();
    chk("sat_stays_hot", 64'(state_o), 64'd1);
    drop_en = 1'b0; tick();
    chk("hot_to_cold", 64'(state_o), 64'd0);

    // Scan wrap from last digit back to digit 0
    found = 1'b0;
    for (int k = 0; k < 30 && dig_sel == 6'b100000; k++) tick();
    for (int k = 0; k < 30; k++) begin
      tick();
      if (dig_sel == 6'b100000) begin found = 1'b1; break; end
    end
    chk("scan_reach_last", 64'(found), 64'd1);
    tick(); tick(); tick();
    chk("scan_wrap", 64'(dig_sel), 64'(6'b000001));
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
